bcd_counter6: RTL

BCD_COUNTER6 -- requirements
Module: bcd_counter6

---
 rtl/bcd_counter6.sv | 103 ++++++++++
 1 files changed

// File: rtl/bcd_counter6.sv
// rtl/bcd_counter6.sv - six-digit BCD up/down counter with prescaled tick and run/stop control
module bcd_counter6 #(
    parameter int TICK_DIV = 5000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        load,
    input  logic        up_down,
    input  logic [23:0] load_val,
    output logic [23:0] bcd,
    output logic        running,
    output logic        tick,
    output logic        wrap,
    output logic        load_err
);

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    localparam logic [24:0] PRESC_MAX = 25'(TICK_DIV - 1);

    state_t      state;
    logic [24:0] presc;
    logic        step;
    logic [23:0] load_clean;
    logic        load_bad;

    // Ripple a +1/-1 through the digits; carry or borrow out of digit 5 is dropped.
    function automatic logic [23:0] bcd_step(input logic [23:0] v, input logic up);
        logic [23:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (c) begin
                if (up) begin
                    if (v[i*4 +: 4] == 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (v[i*4 +: 4] == 4'd0) begin
                        r[i*4 +: 4] = 4'd9;
                    end else begin
                        r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        load_clean = load_val;
        load_bad   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (load_val[i*4 +: 4] > 4'd9) begin
                load_clean[i*4 +: 4] = 4'd0;
                load_bad             = 1'b1;
            end
        end
    end

    assign running = (state == RUNNING);
    assign tick    = running && (presc == PRESC_MAX);
    // A tick shadowed by reset, clear or load moves nothing, so it cannot wrap either.
    assign step    = tick && !clear && !load && !rst;
    assign wrap    = step && (up_down ? (bcd == 24'h999999) : (bcd == 24'h000000));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= STOPPED;
            presc    <= '0;
            bcd      <= '0;
            load_err <= 1'b0;
        end else begin
            if (start_stop) begin
                state <= (state == RUNNING) ? STOPPED : RUNNING;
            end
            load_err <= load && !clear && load_bad;
            if (clear) begin
                bcd   <= '0;
                presc <= '0;
            end else if (load) begin
                bcd   <= load_clean;
                presc <= '0;
            end else if (running) begin
                presc <= tick ? 25'd0 : presc + 25'd1;
                if (tick) begin
                    bcd <= bcd_step(bcd, up_down);
                end
            end
        end
    end

endmodule
